// File: rtl/ofifo_collector_pkg.sv
// Default geometry shared by the output FIFO collector and the mac_row that feeds it.
package ofifo_collector_pkg;
    localparam int default_col     = 8;
    localparam int default_psum_bw = 16;
    localparam int default_depth   = 64;
    localparam int default_ptr_bw  = $clog2(default_depth);
endpackage

// File: rtl/ofifo_collector_fifo_col.sv
// One column FIFO: storage, wrapping pointers, occupancy count and the write-accept rule.
module fifo_col #(
    parameter int psum_bw = 16,
    parameter int depth   = 64,
    parameter int ptr_bw  = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               pop,
    input  logic [psum_bw-1:0] din,
    output logic [psum_bw-1:0] dout,
    output logic               empty,
    output logic               full,
    output logic               drop
);
    localparam logic [ptr_bw:0]   depth_cnt = (ptr_bw+1)'(depth);
    localparam logic [ptr_bw:0]   cnt_one   = (ptr_bw+1)'(1);
    localparam logic [ptr_bw-1:0] ptr_one   = ptr_bw'(1);

    logic [psum_bw-1:0] mem [depth];
    logic [ptr_bw-1:0]  wptr;
    logic [ptr_bw-1:0]  rptr;
    logic [ptr_bw:0]    count;
    logic               accept;

    assign empty  = (count == '0);
    assign full   = (count == depth_cnt);
    // A full column can still take a word when the same edge frees a slot.
    assign accept = wr & (~full | pop);
    assign drop   = wr & full & ~pop;
    assign dout   = mem[rptr];

    always_ff @(posedge clk) begin
        if (accept) mem[wptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (accept) wptr <= wptr + ptr_one;
            if (pop)    rptr <= rptr + ptr_one;
            case ({accept, pop})
                2'b10:   count <= count + cnt_one;
                2'b01:   count <= count - cnt_one;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ofifo_collector.sv
// Deskews per-column psum streams into aligned vectors; out is first-word-fall-through.
module ofifo_collector
    import ofifo_collector_pkg::*;
#(
    parameter int col     = default_col,
    parameter int psum_bw = default_psum_bw,
    parameter int depth   = default_depth,
    parameter int ptr_bw  = default_ptr_bw
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow,
    output logic                   o_underflow
);
    logic [col-1:0] empty;
    logic [col-1:0] full;
    logic [col-1:0] drop;
    logic           pop;

    // Handshake: a vector transfers on any edge where rd and o_valid are both high;
    // rd with o_valid low is ignored (flagged as underflow), writes are accepted while o_ready.
    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;

    for (genvar i = 0; i < col; i++) begin : g_col
        fifo_col #(
            .psum_bw (psum_bw),
            .depth   (depth),
            .ptr_bw  (ptr_bw)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[i]),
            .pop   (pop),
            .din   (in[psum_bw*i +: psum_bw]),
            .dout  (out[psum_bw*i +: psum_bw]),
            .empty (empty[i]),
            .full  (full[i]),
            .drop  (drop[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (|drop)         o_overflow  <= 1'b1;
            if (rd & ~o_valid) o_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ofifo_collector.sv
// Bench for ofifo_collector: directed scenarios plus random traffic against a per-column queue model.
module tb_ofifo_collector;
    localparam int col   = 8;
    localparam int bw    = 16;
    localparam int depth = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [bw*col-1:0] in = '0;
    logic [col-1:0]    wr = '0;
    logic              rd = 1'b0;
    logic [bw*col-1:0] out;
    logic              o_valid, o_full, o_ready, o_overflow, o_underflow;

    int total = 0;
    int bad   = 0;

    logic [bw-1:0] exp_q [col][$];
    logic          ovf_m = 1'b0;
    logic          unf_m = 1'b0;

    ofifo_collector dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .wr          (wr),
        .rd          (rd),
        .out         (out),
        .o_valid     (o_valid),
        .o_full      (o_full),
        .o_ready     (o_ready),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [bw*col-1:0] got, input logic [bw*col-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic model_valid();
        for (int i = 0; i < col; i++) if (exp_q[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic model_full();
        for (int i = 0; i < col; i++) if (exp_q[i].size() == depth) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [bw*col-1:0] model_out();
        logic [bw*col-1:0] v = '0;
        for (int i = 0; i < col; i++) v[bw*i +: bw] = exp_q[i][0];
        return v;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".valid"}, o_valid, model_valid());
        check({tag, ".full"}, o_full, model_full());
        check({tag, ".ready"}, o_ready, !model_full());
        check({tag, ".ovf"}, o_overflow, ovf_m);
        check({tag, ".unf"}, o_underflow, unf_m);
        if (model_valid()) check({tag, ".out"}, out, model_out());
    endtask

    // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
    task automatic cycle(input logic [col-1:0] w, input logic r, input logic [bw*col-1:0] d, input string tag);
        logic pop_m;
        logic was_full;
        wr = w; rd = r; in = d;
        @(posedge clk);
        pop_m = r && model_valid();
        if (r && !model_valid()) unf_m = 1'b1;
        for (int i = 0; i < col; i++) begin
            was_full = (exp_q[i].size() == depth);
            if (pop_m) void'(exp_q[i].pop_front());
            if (w[i]) begin
                if (!was_full || pop_m) exp_q[i].push_back(d[bw*i +: bw]);
                else ovf_m = 1'b1;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rst.valid", o_valid, 1'b0);
        check("rst.full", o_full, 1'b0);
        check("rst.ready", o_ready, 1'b1);
        check("rst.ovf", o_overflow, 1'b0);
        check("rst.unf", o_underflow, 1'b0);
        for (int i = 0; i < col; i++) exp_q[i].delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        wr = '0; rd = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic skewed_fill(input string tag);
        logic [bw*col-1:0] d;
        logic [bw*col-1:0] golden;
        golden = 128'h0107_0106_0105_0104_0103_0102_0101_0100;
        for (int c = 0; c < col; c++) begin
            d = '0;
            d[bw*c +: bw] = 16'h0100 + 16'(c);
            cycle(col'(1) << c, 1'b0, d, tag);
            if (c < col - 1) check({tag, ".early_valid"}, o_valid, 1'b0);
        end
        check({tag, ".valid_rise"}, o_valid, 1'b1);
        check({tag, ".vector"}, out, golden);
        cycle('0, 1'b1, '0, tag);
        check({tag, ".drain"}, o_valid, 1'b0);
    endtask

    logic [bw*col-1:0] v2;
    logic [bw*col-1:0] rnd;

    initial begin
        do_reset();

        // Underflow from an empty collector.
        cycle('0, 1'b1, '0, "unf");
        check("unf.flag", o_underflow, 1'b1);
        check("unf.valid", o_valid, 1'b0);
        cycle('0, 1'b0, '0, "unf_hold");

        do_reset();
        skewed_fill("skew1");

        // Streaming with wrap: pop continuously once a vector is available.
        do_reset();
        for (int c = 0; c < 200; c++)
            cycle('1, model_valid(), {col{16'(c)}}, "stream");
        check("stream.no_full", o_full, 1'b0);

        // Single column to full, then one dropped write.
        do_reset();
        for (int c = 0; c < depth; c++) cycle(8'h08, 1'b0, {col{16'(c)}}, "col3");
        check("col3.full", o_full, 1'b1);
        check("col3.ovf_before", o_overflow, 1'b0);
        cycle(8'h08, 1'b0, {col{16'hDEAD}}, "col3_drop");
        check("col3.ovf", o_overflow, 1'b1);
        check("col3.valid", o_valid, 1'b0);

        // Everything full, then simultaneous push and pop.
        do_reset();
        v2 = '0;
        for (int c = 0; c < depth; c++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            if (c == 1) v2 = rnd;
            cycle('1, 1'b0, rnd, "fill");
        end
        check("fill.full", o_full, 1'b1);
        cycle('1, 1'b1, {$urandom, $urandom, $urandom, $urandom}, "pushpop");
        check("pushpop.full", o_full, 1'b1);
        check("pushpop.ovf", o_overflow, 1'b0);
        check("pushpop.second", out, v2);

        // Reset in the middle of a stream with ten vectors buffered.
        do_reset();
        for (int c = 0; c < 10; c++) cycle('1, 1'b0, {col{16'(c + 1)}}, "pre_rst");
        do_reset();
        skewed_fill("skew2");

        // Random traffic with mixed strobes and a bias toward filling.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            cycle(8'($urandom), ($urandom_range(0, 9) < ((c / 150) % 2 == 0 ? 3 : 8)), rnd, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ofifo_collector.md
Name: ofifo_collector

Overview:
- Receives the skewed psum outputs of the bottom mac_row: one psum_bw word per column, each qualified by its own valid bit.
- Columns become valid on different cycles, one cycle of skew per column. Each column is buffered in its own FIFO.
- When every column holds at least one word, a complete, aligned output vector is presented for the downstream SFU/memory writer to pop.

Parameters:
- col, 8, number of columns; must match the mac_row col.
- psum_bw, 16, width of one psum word.
- depth, 64, entries per column FIFO; power of two, at least 2.
- ptr_bw, 6, log2(depth); read/write pointer width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in  input  psum_bw*col  psum words from mac_row out_s; column i occupies bits [psum_bw*(i+1)-1 : psum_bw*i]
- wr  input  col  per-column write strobe, driven from mac_row valid
- rd  input  1  pop request for one full aligned vector
- out  output  psum_bw*col  head word of every column, same packing as in
- o_valid  output  1  every column FIFO is non-empty
- o_full  output  1  at least one column FIFO is full
- o_ready  output  1  no column FIFO is full (equals ~o_full)
- o_overflow  output  1  sticky: a write was dropped
- o_underflow  output  1  sticky: rd was asserted while o_valid was low

Behaviour:
- Reset (asynchronous, active-high):
  - all write pointers, read pointers and counts go to 0;
  - o_valid=0, o_full=0, o_ready=1, o_overflow=0, o_underflow=0;
  - out is don't-care but must be driven with no X from the control logic;
  - FIFO storage is not cleared.
- Each column i keeps a write pointer, a read pointer (ptr_bw bits, wrapping modulo depth) and a count (ptr_bw+1 bits, range 0..depth).
- Write:
  - on a rising edge with wr[i]=1, the psum word for column i is stored at wptr[i] and wptr[i] increments;
  - this is accepted if count[i]<depth, or if count[i]==depth and a pop occurs in the same cycle;
  - otherwise the word is dropped, wptr and count are unchanged, and o_overflow is set.
- Pop:
  - pop = rd & o_valid;
  - on a pop, every column's rptr increments simultaneously;
  - rd while o_valid=0 is ignored and sets o_underflow.
- Count update per column: +1 on write only, -1 on pop only, unchanged when both or neither occur.
- out is first-word-fall-through: combinational read of mem[rptr[i]] for each column, valid whenever o_valid=1.
- Flags:
  - o_valid = AND over all columns of (count[i]!=0);
  - o_full = OR over all columns of (count[i]==depth).
  - Both are derived from registered counts, so they update in the cycle after the causing edge.
- Latency: a word written at edge N is visible at out after edge N, once all columns have data.
  - With column skew, the first vector becomes valid the cycle after column col-1 writes.
- Wrap-around: pointers wrap depth-1 → 0 with no bubble.
- Column strobes wr[i] are independent; any subset may assert in the same cycle.
- Sticky flags clear only on reset.
- Reset mid-operation: all buffered data is discarded and the next cycle behaves as post-reset.

Decomposition:
- No shared package is needed; parameters are passed down by the instantiator. A shared constants header may hold the default col/psum_bw values that also feed mac_row.
- One sub-module, fifo_col (params psum_bw, depth, ptr_bw), instantiated col times in a generate loop.
  - Inputs: clk, reset, wr, pop, din. Outputs: dout, empty, full, drop.
  - Implements storage, pointers, count and the write-accept rule.
- The top level aggregates o_valid and o_full, forms pop, and holds the sticky flags.

Test Plan:
1. Skewed fill: col=8. Column i writes value 0x0100+i at cycle i (wr one-hot, shifting left each cycle).
   - o_valid must be 0 through cycle 7 and rise after cycle 7.
   - out must read 0x0107_0106_..._0100.
   - rd=1 for one cycle → o_valid returns to 0.
2. Streaming: all wr=1 every cycle with data = cycle count, and rd=1 continuously once o_valid=1.
   - Run 200 cycles (more than 3×depth).
   - Popped vectors must be in order with no loss; pointers wrap; o_full never asserts.
3. Full / overflow: write 64 words to column 3 only, then write 0xDEAD to column 3.
   - o_full=1 after the 64th write.
   - The 65th write is dropped and o_overflow=1.
   - Other columns remain empty.
4. Full with simultaneous push and pop: bring all columns to count=64, then assert wr=all-ones and rd=1 in the same cycle.
   - Write is accepted, count stays 64, o_overflow stays 0.
   - The next vector out is the 2nd vector that was written.
5. Underflow: from reset, assert rd=1 with wr=0.
   - o_underflow=1; pointers unchanged; o_valid stays 0.
6. Async reset mid-stream: with count=10 in every column, assert reset between clock edges.
   - o_valid, o_full and the sticky flags drop immediately, without waiting for a clock edge.
   - After release, a fresh skewed fill behaves exactly as scenario 1.
